// File: rtl/mem_port_arbiter.sv
// Shares the core's single external memory port between instruction fetch and data access.
// One transaction is outstanding at a time. MEM wins arbitration unless IF has already lost MAX_WAIT grants in a row.
module mem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_request,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [31:0]         if_inst,
    output logic                if_stall,
    input  logic                flush,
    input  logic                mem_re,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stall,
    output logic                bus_req,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_we,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wmask,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    typedef enum logic [2:0] {IDLE, REQ_IF, REQ_MEM, WAIT_IF, WAIT_MEM} state_t;

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              drop;
    logic [31:0]       if_inst_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_pend;
    logic              if_win;
    logic              mem_win;
    logic              if_done;
    logic              mem_done;
    logic [31:0]       fetch_word;

    assign mem_pend = mem_re | mem_we;
    assign if_win   = (state == IDLE) && if_request && (!mem_pend || wait_cnt == CNT_MAX);
    assign mem_win  = (state == IDLE) && mem_pend && !if_win;

    // The fetch address selects which 32-bit half of the bus word holds the instruction.
    assign fetch_word = bus_addr[2] ? bus_rdata[63:32] : bus_rdata[31:0];

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            IDLE: begin
                if (if_win)       next_state = REQ_IF;
                else if (mem_win) next_state = REQ_MEM;
            end
            REQ_IF:   if (bus_gnt)    next_state = WAIT_IF;
            REQ_MEM:  if (bus_gnt)    next_state = WAIT_MEM;
            WAIT_IF,
            WAIT_MEM: if (bus_rvalid) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        if_done  = 1'b0;
        mem_done = 1'b0;
        case (state)
            WAIT_IF:  if_done  = bus_rvalid && !drop && !flush;
            WAIT_MEM: mem_done = bus_rvalid;
            default:  ;
        endcase
    end

    assign if_stall  = if_request && !if_done;
    assign mem_stall = mem_pend && !mem_done;
    assign if_inst   = if_done  ? fetch_word : if_inst_q;
    assign mem_rdata = mem_done ? bus_rdata  : mem_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req     <= 1'b0;
            bus_addr    <= '0;
            bus_we      <= 1'b0;
            bus_wdata   <= '0;
            bus_wmask   <= '0;
            wait_cnt    <= '0;
            drop        <= 1'b0;
            // NOTE: the held response registers are plain flops and are cleared, so outputs are defined after reset.
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            bus_req <= (next_state == REQ_IF) || (next_state == REQ_MEM);

            if (if_win) begin
                bus_addr  <= if_addr;
                bus_we    <= 1'b0;
                bus_wdata <= '0;
                bus_wmask <= '0;
            end else if (mem_win) begin
                bus_addr  <= mem_addr;
                bus_we    <= mem_we;
                bus_wdata <= mem_wdata;
                bus_wmask <= mem_wmask;
            end

            // Counts MEM grants that IF sat through; IF is forced through once it saturates.
            if (state == IDLE) begin
                if (if_win || !if_request)
                    wait_cnt <= '0;
                else if (mem_win && wait_cnt != CNT_MAX)
                    wait_cnt <= wait_cnt + 1'b1;
            end

            if (next_state == IDLE)
                drop <= 1'b0;
            else if (flush && (state == REQ_IF || state == WAIT_IF))
                drop <= 1'b1;

            if (if_done)  if_inst_q   <= fetch_word;
            if (mem_done) mem_rdata_q <= bus_rdata;
        end
    end

endmodule
